board_io_conditioner: RTL and testbench
=======================================

Name: board_io_conditioner

Overview:
- Parametrised board-level I/O conditioning stage between FPGA pins and the SoC GPIO/peripheral ports on the Nexys A7 top.
- Inputs (slide switches): synchronised, debounced, edge-detected, with a maskable sticky interrupt.
- Outputs (LEDs): global PWM brightness.
- PMOD header pins: synchronised inputs and registered, glitch-free output-enable/data.
- Channel counts, debounce time and PWM resolution are parameters.

Parameters:
N_SW, 16, number of debounced input channels
N_LED, 16, number of PWM-driven LED channels
N_PMOD, 8, number of PMOD pins
SYNC_STAGES, 2, synchroniser depth (>=2)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles to accept a new level (>=1)
PWM_BITS, 4, PWM counter/duty width (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sw_i  in  N_SW  raw asynchronous switch pins
sw_o  out  N_SW  debounced level
sw_rise_o  out  N_SW  one-cycle pulse on debounced 0->1
sw_fall_o  out  N_SW  one-cycle pulse on debounced 1->0
irq_mask_i  in  N_SW  1 = channel excluded from irq
irq_clr_i  in  1  clears sticky irq
irq_o  out  1  sticky edge interrupt
led_val_i  in  N_LED  requested LED on/off per channel
led_duty_i  in  PWM_BITS  global brightness
led_o  out  N_LED  LED pins
pmod_in_i  in  N_PMOD  raw PMOD pin values
pmod_in_o  out  N_PMOD  synchronised PMOD values
pmod_out_i  in  N_PMOD  PMOD data from SoC
pmod_dir_i  in  N_PMOD  1 = pin driven
pmod_o  out  N_PMOD  registered PMOD data
pmod_oe_o  out  N_PMOD  registered output enable (top builds tristate)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; all state is sampled at posedge clk.
- Reset values:
  - Synchroniser flops, debounce counters, PWM counter: 0.
  - sw_o, sw_rise_o, sw_fall_o, irq_o, led_o, pmod_in_o, pmod_o, pmod_oe_o: 0. All PMOD pins are inputs after reset.
- Synchronisers:
  - Each sw_i/pmod_in_i bit passes through a SYNC_STAGES-flop chain.
  - pmod_in_o is the chain output; latency is SYNC_STAGES cycles.
- Debounce, per channel, with s = synchronised bit and counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s == sw_o: counter <= 0.
  - If s != sw_o and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s != sw_o and counter == DEBOUNCE_CYCLES-1: sw_o <= s, counter <= 0, and the matching rise/fall pulse is high for exactly the next cycle, together with the new sw_o.
  - Any single-cycle return of s to sw_o restarts the count.
  - A clean step on sw_i changes sw_o SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first sampling edge.
  - DEBOUNCE_CYCLES=1 degenerates to synchroniser plus edge detect.
- Interrupt:
  - irq_o <= (irq_o & ~irq_clr_i) | |((sw_rise_o | sw_fall_o) & ~irq_mask_i).
  - Set wins over simultaneous clear.
  - Mask changes do not retroactively clear irq_o.
- PWM:
  - cnt is a free-running PWM_BITS counter that wraps from all-ones to 0.
  - on = (led_duty_i == all-ones) | (cnt < led_duty_i).
  - led_o[i] <= led_val_i[i] & on (registered, 1-cycle latency).
  - Duty 0 = off. Duty d (0<d<max) = d high cycles per 2^PWM_BITS period, starting at cnt==0. All-ones = constant on.
  - A duty change takes effect on the next cycle with no period resync.
- PMOD: pmod_o <= pmod_out_i and pmod_oe_o <= pmod_dir_i every cycle (1-cycle latency, no combinational path pin-to-pin).
- Reset mid-operation:
  - Counters are discarded and sw_o returns to 0.
  - After release, a held-high switch re-qualifies in full (SYNC_STAGES+DEBOUNCE_CYCLES) and produces one rise pulse plus irq if unmasked.

Test Plan:
1. Reset, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, sw_i held 0 -> all outputs 0, pmod_oe_o=0 for 20 cycles.
2. sw_i[3] 0->1 with glitches of 1..7 cycles high, then held -> sw_o[3] rises exactly 10 cycles after the final step is sampled. sw_rise_o[3] is high for 1 cycle simultaneously. No pulses during the glitches.
3. irq_mask_i=16'hFFF7: toggle sw_i[0] -> irq_o stays 0. Then toggle sw_i[3] -> irq_o=1. Assert irq_clr_i on the same cycle as a new sw_fall_o[3] -> irq_o stays 1. Clear alone -> irq_o=0.
4. PWM_BITS=4, led_val_i=16'h0001: duty 4 -> led_o[0] high 4 of every 16 cycles. Duty 0 -> always 0. Duty 15 -> always 1. led_o[15:1] stay 0.
5. Assert rst at counter=5 of a pending sw_i[7] edge (sw_i held 1) -> sw_o[7]=0 after reset. After release, sw_o[7]=1 exactly 10 cycles later with one rise pulse.
6. pmod_dir_i=8'hF0, pmod_out_i=8'hA5 -> pmod_oe_o=8'hF0, pmod_o=8'hA5 one cycle later. pmod_in_i=8'h3C -> pmod_in_o=8'h3C after 2 cycles.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Board-level I/O conditioning: switch synchronise/debounce/edge/irq, LED PWM,
// and registered PMOD data/output-enable with synchronised PMOD inputs.
module board_io_conditioner #(
  parameter int unsigned N_SW            = 16,
  parameter int unsigned N_LED           = 16,
  parameter int unsigned N_PMOD          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PWM_BITS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SW-1:0]     sw_i,
  output logic [N_SW-1:0]     sw_o,
  output logic [N_SW-1:0]     sw_rise_o,
  output logic [N_SW-1:0]     sw_fall_o,
  input  logic [N_SW-1:0]     irq_mask_i,
  input  logic                irq_clr_i,
  output logic                irq_o,
  input  logic [N_LED-1:0]    led_val_i,
  input  logic [PWM_BITS-1:0] led_duty_i,
  output logic [N_LED-1:0]    led_o,
  input  logic [N_PMOD-1:0]   pmod_in_i,
  output logic [N_PMOD-1:0]   pmod_in_o,
  input  logic [N_PMOD-1:0]   pmod_out_i,
  input  logic [N_PMOD-1:0]   pmod_dir_i,
  output logic [N_PMOD-1:0]   pmod_o,
  output logic [N_PMOD-1:0]   pmod_oe_o
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]     r_sw_sync   [SYNC_STAGES];
  logic [N_PMOD-1:0]   r_pmod_sync [SYNC_STAGES];
  logic [CW-1:0]       r_db_cnt    [N_SW];
  logic [N_SW-1:0]     r_sw;
  logic [N_SW-1:0]     r_rise;
  logic [N_SW-1:0]     r_fall;
  logic                r_irq;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N_LED-1:0]    r_led;
  logic [N_PMOD-1:0]   r_pmod_o;
  logic [N_PMOD-1:0]   r_pmod_oe;

  logic [N_SW-1:0]     w_sw_s;
  logic                w_pwm_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sw_sync[k]   <= '0;
        r_pmod_sync[k] <= '0;
      end
    end else begin
      r_sw_sync[0]   <= sw_i;
      r_pmod_sync[0] <= pmod_in_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sw_sync[k]   <= r_sw_sync[k-1];
        r_pmod_sync[k] <= r_pmod_sync[k-1];
      end
    end
  end

  assign w_sw_s = r_sw_sync[SYNC_STAGES-1];

  // Counter only advances while the synchronised level disagrees with the
  // accepted level; any agreeing cycle restarts qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (w_sw_s[i] == r_sw[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_LAST) begin
          r_sw[i]     <= w_sw_s[i];
          r_rise[i]   <= w_sw_s[i];
          r_fall[i]   <= ~w_sw_s[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_irq & ~irq_clr_i) | (|((r_rise | r_fall) & ~irq_mask_i));
    end
  end

  assign w_pwm_on = (&led_duty_i) | (r_pwm_cnt < led_duty_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
      r_pmod_o  <= '0;
      r_pmod_oe <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_led     <= led_val_i & {N_LED{w_pwm_on}};
      r_pmod_o  <= pmod_out_i;
      r_pmod_oe <= pmod_dir_i;
    end
  end

  assign sw_o      = r_sw;
  assign sw_rise_o = r_rise;
  assign sw_fall_o = r_fall;
  assign irq_o     = r_irq;
  assign led_o     = r_led;
  assign pmod_in_o = r_pmod_sync[SYNC_STAGES-1];
  assign pmod_o    = r_pmod_o;
  assign pmod_oe_o = r_pmod_oe;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed bench for board_io_conditioner: reset, debounce glitches, irq
// mask/clear, PWM duty and PMOD latency tables, reset during qualification.
module tb_board_io_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i, sw_o, sw_rise_o, sw_fall_o, irq_mask_i;
  logic        irq_clr_i, irq_o;
  logic [15:0] led_val_i, led_o;
  logic [3:0]  led_duty_i;
  logic [7:0]  pmod_in_i, pmod_in_o, pmod_out_i, pmod_dir_i, pmod_o, pmod_oe_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  board_io_conditioner #(
    .N_SW(16), .N_LED(16), .N_PMOD(8),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_i(sw_i), .sw_o(sw_o), .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o),
    .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i), .irq_o(irq_o),
    .led_val_i(led_val_i), .led_duty_i(led_duty_i), .led_o(led_o),
    .pmod_in_i(pmod_in_i), .pmod_in_o(pmod_in_o),
    .pmod_out_i(pmod_out_i), .pmod_dir_i(pmod_dir_i),
    .pmod_o(pmod_o), .pmod_oe_o(pmod_oe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dir, out, pin;
    logic [15:0] val;
    logic [3:0]  duty;
    logic [7:0]  exp_oe, exp_o, exp_in;
    int unsigned exp_on;   // high cycles per 16 on an enabled LED bit
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  prev_in;
    int unsigned c0, c15, stray;

    vecs[0] = '{8'hF0, 8'hA5, 8'h3C, 16'h0001, 4'd4,  8'hF0, 8'hA5, 8'h3C, 4};
    vecs[1] = '{8'h0F, 8'h5A, 8'hC3, 16'h0001, 4'd0,  8'h0F, 8'h5A, 8'hC3, 0};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 16'h0001, 4'd15, 8'hFF, 8'hFF, 8'hFF, 16};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 16'h8001, 4'd1,  8'h00, 8'h00, 8'h00, 1};
    vecs[4] = '{8'h81, 8'h7E, 8'h81, 16'hFFFF, 4'd14, 8'h81, 8'h7E, 8'h81, 14};
    vecs[5] = '{8'hF0, 8'hA5, 8'h3C, 16'h0000, 4'd15, 8'hF0, 8'hA5, 8'h3C, 16};

    rst = 1'b1; sw_i = '0; irq_mask_i = '0; irq_clr_i = 1'b0;
    led_val_i = '0; led_duty_i = '0;
    pmod_in_i = '0; pmod_out_i = '0; pmod_dir_i = '0;

    // Reset and idle
    repeat (3) tick();
    check("reset_state", {sw_o, sw_rise_o, sw_fall_o, irq_o, led_o, pmod_in_o, pmod_o, pmod_oe_o}, '0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_zero", {sw_o, sw_rise_o, sw_fall_o, irq_o, led_o, pmod_in_o, pmod_o, pmod_oe_o}, '0);
    end

    // Glitches of 1..7 cycles must never qualify
    for (int g = 1; g <= 7; g++) begin
      sw_i[3] = 1'b1;
      repeat (g) begin
        tick();
        check("glitch_hi", {sw_o[3], sw_rise_o[3], sw_fall_o[3]}, '0);
      end
      sw_i[3] = 1'b0;
      repeat (4) begin
        tick();
        check("glitch_lo", {sw_o[3], sw_rise_o[3], sw_fall_o[3]}, '0);
      end
    end
    sw_i[3] = 1'b1;
    repeat (9) tick();
    check("step_edge9", {sw_o[3], sw_rise_o[3]}, 2'b00);
    tick();
    check("step_edge10", {sw_o[3], sw_rise_o[3]}, 2'b11);
    tick();
    check("step_edge11", {sw_o[3], sw_rise_o[3]}, 2'b10);

    // Interrupt mask / clear behaviour
    irq_mask_i = 16'hFFF7;
    irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
    check("irq_cleared", irq_o, 1'b0);
    sw_i[0] = 1'b1; repeat (12) tick();
    check("masked_sw0_level", sw_o[0], 1'b1);
    check("masked_rise_irq", irq_o, 1'b0);
    sw_i[0] = 1'b0; repeat (12) tick();
    check("masked_fall_irq", irq_o, 1'b0);
    sw_i[3] = 1'b0; repeat (12) tick();
    check("unmasked_irq", irq_o, 1'b1);
    irq_mask_i = 16'hFFFF; tick();
    check("mask_no_retro_clear", irq_o, 1'b1);
    irq_mask_i = 16'hFFF7;
    sw_i[3] = 1'b1; repeat (12) tick();
    sw_i[3] = 1'b0; repeat (10) tick();
    check("fall_pulse", sw_fall_o[3], 1'b1);
    irq_clr_i = 1'b1; tick();
    check("set_wins_clear", irq_o, 1'b1);
    tick();
    check("clear_alone", irq_o, 1'b0);
    irq_clr_i = 1'b0;

    // Reset while sw_i[7] is part-way through qualification
    irq_mask_i = '0;
    sw_i[7] = 1'b1;
    repeat (7) tick();
    check("pending_not_yet", sw_o[7], 1'b0);
    rst = 1'b1; tick(); tick();
    check("midrst_state", {sw_o, sw_rise_o, irq_o}, '0);
    rst = 1'b0;
    repeat (9) tick();
    check("post_rst_edge9", {sw_o[7], sw_rise_o[7]}, 2'b00);
    tick();
    check("post_rst_edge10", {sw_o[7], sw_rise_o[7], irq_o}, 3'b110);
    tick();
    check("post_rst_edge11", {sw_o[7], sw_rise_o[7], irq_o}, 3'b101);
    sw_i[7] = 1'b0;

    // PMOD latency and PWM duty table
    prev_in = 8'h00;
    for (int v = 0; v < 6; v++) begin
      pmod_dir_i = vecs[v].dir; pmod_out_i = vecs[v].out; pmod_in_i = vecs[v].pin;
      led_val_i  = vecs[v].val; led_duty_i = vecs[v].duty;
      tick();
      check("pmod_oe", pmod_oe_o, vecs[v].exp_oe);
      check("pmod_o", pmod_o, vecs[v].exp_o);
      check("pmod_in_lat1", pmod_in_o, prev_in);
      tick();
      check("pmod_in_lat2", pmod_in_o, vecs[v].exp_in);
      prev_in = vecs[v].exp_in;
      c0 = 0; c15 = 0; stray = 0;
      for (int c = 0; c < 16; c++) begin
        tick();
        c0  += led_o[0];
        c15 += led_o[15];
        if ((led_o & ~vecs[v].val) != '0) stray++;
      end
      check("led0_on_cycles", c0, vecs[v].val[0] ? vecs[v].exp_on : 0);
      check("led15_on_cycles", c15, vecs[v].val[15] ? vecs[v].exp_on : 0);
      check("led_stray", stray, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
